// File: rtl/llr_hard_decision_qber_est.sv
// llr_hard_decision_qber_est: hard-decides posterior LLRs, counts corrections per frame and maps the frame QBER to a LUT index
//  clk, rst                 rising-edge clock, synchronous active-high reset
//  in_valid/in_ready        input handshake for llr_in (signed Q5.10) and xi_in (raw received bit)
//  bit_valid/bit_out/bit_flip  registered hard decision and correction flag, one pulse per accepted beat
//  qber_valid/err_count/qber_sel  per-frame pulse with held correction count and QBER index 0..10
module llr_hard_decision_qber_est #(
   parameter int LLR_W     = 15,
   parameter int FRAME_LEN = 1024,
   parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LLR_W-1:0] llr_in,
   input  logic             xi_in,
   output logic             bit_valid,
   output logic             bit_out,
   output logic             bit_flip,
   output logic             qber_valid,
   output logic [CNT_W-1:0] err_count,
   output logic [3:0]       qber_sel
);
   localparam int CW = CNT_W + 8;
   typedef enum logic [1:0] {ACCUM, EVAL, DONE} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] bit_cnt, err_cnt, err_reg;
   logic [3:0] k;
   logic [4:0] mult;
   logic [CW-1:0] lhs, rhs;
   logic xfer, flip, last, hit;
   assign in_ready = state == ACCUM;
   assign xfer = in_valid & in_ready;
   assign flip = llr_in[LLR_W-1] ^ xi_in;
   assign last = bit_cnt == CNT_W'(FRAME_LEN - 1);
   // (2k+3) as {k,1} + 2; both products fit CW bits without truncation
   assign mult = {k, 1'b1} + 5'd2;
   assign lhs = CW'(err_reg) * CW'(200);
   assign rhs = CW'(mult) * CW'(FRAME_LEN);
   assign hit = lhs < rhs;
   always_comb begin
      state_n = state == ACCUM ? (xfer && last ? EVAL : ACCUM)
              : state == EVAL  ? (hit || k == 4'd10 ? DONE : EVAL)
              : ACCUM;
   end
   // k stops advancing on the first hit or at 10, so it already equals the clamped index at DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ACCUM;
         bit_cnt    <= '0;
         err_cnt    <= '0;
         err_reg    <= '0;
         k          <= '0;
         bit_valid  <= 1'b0;
         bit_out    <= 1'b0;
         bit_flip   <= 1'b0;
         qber_valid <= 1'b0;
         err_count  <= '0;
         qber_sel   <= '0;
      end else begin
         state      <= state_n;
         bit_valid  <= xfer;
         qber_valid <= state == DONE;
         if (xfer) begin
            bit_out  <= llr_in[LLR_W-1];
            bit_flip <= flip;
            bit_cnt  <= last ? '0 : bit_cnt + CNT_W'(1);
            err_cnt  <= last ? '0 : err_cnt + CNT_W'(flip);
         end
         if (xfer && last) begin
            err_reg <= err_cnt + CNT_W'(flip);
            k       <= '0;
         end
         if (state == EVAL && !hit && k != 4'd10) k <= k + 4'd1;
         if (state == DONE) begin
            qber_sel  <= k;
            err_count <= err_reg;
         end
      end
   end
endmodule

// File: tb/tb_llr_hard_decision_qber_est.sv
// tb_llr_hard_decision_qber_est: scoreboard bench for the hard-decision / QBER estimator with FRAME_LEN=100
module tb_llr_hard_decision_qber_est;
   localparam int N  = 100;
   localparam int LW = 15;
   localparam int CW = $clog2(N + 1);
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, xi_in = 1'b0;
   logic [LW-1:0] llr_in = '0;
   logic in_ready, bit_valid, bit_out, bit_flip, qber_valid;
   logic [CW-1:0] err_count;
   logic [3:0] qber_sel;
   llr_hard_decision_qber_est #(.LLR_W(LW), .FRAME_LEN(N)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .llr_in(llr_in), .xi_in(xi_in), .bit_valid(bit_valid), .bit_out(bit_out),
      .bit_flip(bit_flip), .qber_valid(qber_valid), .err_count(err_count), .qber_sel(qber_sel)
   );
   always #5 clk = ~clk;
   int tests = 0, fails = 0;
   int cyc = 0, last_xfer = 0, low_run = 0, nbit = 0, nqv = 0;
   int fbeats = 0, fflips = 0;
   logic [1:0] bq[$];
   int qe[$], qs[$];
   logic [1:0] be;
   int ee, es;
   // Expected index: round(100*e/N) with ties up, minus one, clamped to 0..10
   function automatic int ref_sel(int e);
      int s = (200 * e + N) / (2 * N) - 1;
      return s < 0 ? 0 : (s > 10 ? 10 : s);
   endfunction
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (!rst) begin
         if (bit_valid) begin
            nbit++;
            if (bq.size() == 0) chk("bit_unexpected", 1, 0);
            else begin
               be = bq.pop_front();
               chk("bit_out", bit_out, be[1]);
               chk("bit_flip", bit_flip, be[0]);
            end
         end
         if (qber_valid) begin
            nqv++;
            if (qe.size() == 0) chk("qber_unexpected", 1, 0);
            else begin
               ee = qe.pop_front();
               es = qs.pop_front();
               chk("err_count", err_count, ee);
               chk("qber_sel", qber_sel, es);
               chk("qber_latency", cyc - last_xfer, es + 2);
               chk("ready_gap", low_run, es + 2);
            end
         end
         low_run = in_ready ? 0 : low_run + 1;
         if (in_valid && in_ready) last_xfer = cyc + 1;
      end
   end
   task automatic send(logic [LW-1:0] llr, logic xi);
      logic b, f;
      in_valid = 1'b1;
      llr_in = llr;
      xi_in = xi;
      b = $signed(llr) < 0;
      f = b ^ xi;
      for (int t = 0; !in_ready; t++) begin
         if (t > 50) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: in_ready 0 expected 1");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $fatal(1, "in_ready stuck low");
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bq.push_back({b, f});
      fbeats++;
      fflips += int'(f);
      if (fbeats == N) begin
         qe.push_back(fflips);
         qs.push_back(ref_sel(fflips));
         fbeats = 0;
         fflips = 0;
      end
   endtask
   task automatic idle(int n);
      in_valid = 1'b0;
      llr_in = LW'($urandom);
      xi_in = 1'($urandom);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bq.delete();
      qe.delete();
      qs.delete();
      fbeats = 0;
      fflips = 0;
      low_run = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_bit_valid", bit_valid, 0);
      chk("rst_bit_out", bit_out, 0);
      chk("rst_qber_valid", qber_valid, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_qber_sel", qber_sel, 0);
   endtask
   task automatic frame(int nflip, bit gaps, int beats = N);
      bit fl[N];
      bit t, b;
      int j;
      logic [LW-1:0] llr;
      for (int i = 0; i < N; i++) fl[i] = i < nflip;
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = fl[i];
         fl[i] = fl[j];
         fl[j] = t;
      end
      for (int i = 0; i < beats; i++) begin
         b = 1'($urandom_range(1, 0));
         llr = b ? LW'(-int'($urandom_range(16384, 1))) : LW'($urandom_range(16383, 0));
         if (!b && $urandom_range(7, 0) == 0) llr = '0;
         if (gaps && $urandom_range(3, 0) == 0) idle($urandom_range(3, 1));
         send(llr, b ^ fl[i]);
      end
   endtask
   initial begin
      int b0, q0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();
      for (int i = 0; i < N; i++) send(15'h0400, 1'b0);
      idle(15);
      for (int i = 0; i < N; i++) send(i == 10 || i == 50 || i == 99 ? 15'h7C00 : 15'h0400, 1'b0);
      idle(15);
      frame(20, 1'b0);
      idle(15);
      send(15'h0000, 1'b1);
      for (int i = 1; i < N; i++) send(i < 5 ? 15'h7C00 : 15'h0400, 1'b0);
      idle(15);
      b0 = nbit;
      q0 = nqv;
      frame($urandom_range(30, 0), 1'b0);
      frame($urandom_range(30, 0), 1'b0);
      idle(20);
      chk("b2b_bits", nbit - b0, 2 * N);
      chk("b2b_qvalid", nqv - q0, 2);
      frame(10, 1'b1, 50);
      do_reset();
      frame(9, 1'b1);
      idle(15);
      frame(25, 1'b0);
      idle(3);
      do_reset();
      frame(12, 1'b1);
      for (int r = 0; r < 4; r++) frame($urandom_range(25, 0), 1'b1);
      idle(30);
      chk("bits_drained", bq.size(), 0);
      chk("frames_drained", qe.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #2000000;
      tests++;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end
endmodule
